// File: rtl/alu_issue_ctrl.sv
// Issue controller for a combinational ALU: registers operands, waits SETTLE
// cycles for the ALU to settle, captures the result and holds it for a response handshake.
module alu_issue_ctrl #(
    parameter int n      = 8,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [n-1:0] cmd_a,
    input  logic [n-1:0] cmd_b,
    input  logic [2:0]   cmd_op,
    output logic [n-1:0] alu_A,
    output logic [n-1:0] alu_B,
    output logic [2:0]   alu_OpCode,
    input  logic [n-1:0] alu_Result,
    input  logic         alu_Z_flag,
    input  logic         alu_C_flag,
    input  logic         alu_C_out,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [n-1:0] rsp_result,
    output logic         rsp_z,
    output logic         rsp_c,
    output logic         rsp_cout,
    output logic         busy,
    output logic [15:0]  ops_done
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

    logic [1:0]   r_state;
    logic [3:0]   r_cnt;
    logic [n-1:0] r_alu_a;
    logic [n-1:0] r_alu_b;
    logic [2:0]   r_alu_op;
    logic [n-1:0] r_rsp_result;
    logic         r_rsp_z;
    logic         r_rsp_c;
    logic         r_rsp_cout;
    logic [15:0]  r_ops_done;
    logic         w_accept;

    // A new command may be taken in the same cycle the previous response drains.
    assign cmd_ready = (r_state == S_IDLE) || ((r_state == S_RESP) && rsp_ready);
    assign w_accept  = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_rsp_result <= '0;
            r_rsp_z      <= 1'b0;
            r_rsp_c      <= 1'b0;
            r_rsp_cout   <= 1'b0;
            r_ops_done   <= '0;
        end else begin
            case (r_state)
                S_EXEC: begin
                    if (r_cnt == 4'd0) begin
                        r_rsp_result <= alu_Result;
                        r_rsp_z      <= alu_Z_flag;
                        r_rsp_c      <= alu_C_flag;
                        r_rsp_cout   <= alu_C_out;
                        r_state      <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_ops_done <= r_ops_done + 16'd1;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            // Accept overrides the RESP->IDLE move for back-to-back issue.
            if (w_accept) begin
                r_alu_a  <= cmd_a;
                r_alu_b  <= cmd_b;
                r_alu_op <= cmd_op;
                r_cnt    <= SETTLE_M1;
                r_state  <= S_EXEC;
            end
        end
    end

    assign alu_A      = r_alu_a;
    assign alu_B      = r_alu_b;
    assign alu_OpCode = r_alu_op;
    assign rsp_result = r_rsp_result;
    assign rsp_z      = r_rsp_z;
    assign rsp_c      = r_rsp_c;
    assign rsp_cout   = r_rsp_cout;
    assign rsp_valid  = (r_state == S_RESP);
    assign busy       = (r_state != S_IDLE);
    assign ops_done   = r_ops_done;
endmodule
